cond_unit: RTL and testbench

- Conditional-execution stage that sits directly downstream of the instruction decoder.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against the current flags.
- Gates the decoder's PCS/RegW/MemW strobes into the final PCSrc/RegWrite/MemWrite, and updates individual flags from the ALU under the decoder's per-bit FlagW enables.
- Also supplies the carry-in for ADC/SBC/RSC and keeps a saturating count of squashed instructions for debug.

---
 rtl/arm_pkg.sv | 46 ++++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_unit.sv | 82 ++++++++
 tb/tb_cond_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM definitions: condition codes, NZCV bit positions and ALU opcodes.
// Used by the decoder, the conditional-execution stage and the hazard unit.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int NEG = 3;
    localparam int ZER = 2;
    localparam int CAR = 1;
    localparam int OVR = 0;

    localparam logic [3:0] ALU_AND = 4'h0;
    localparam logic [3:0] ALU_EOR = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_RSB = 4'h3;
    localparam logic [3:0] ALU_ADD = 4'h4;
    localparam logic [3:0] ALU_ADC = 4'h5;
    localparam logic [3:0] ALU_SBC = 4'h6;
    localparam logic [3:0] ALU_RSC = 4'h7;
    localparam logic [3:0] ALU_TST = 4'h8;
    localparam logic [3:0] ALU_TEQ = 4'h9;
    localparam logic [3:0] ALU_CMP = 4'hA;
    localparam logic [3:0] ALU_CMN = 4'hB;
    localparam logic [3:0] ALU_ORR = 4'hC;
    localparam logic [3:0] ALU_MOV = 4'hD;
    localparam logic [3:0] ALU_BIC = 4'hE;
    localparam logic [3:0] ALU_MVN = 4'hF;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: Cond x NZCV -> pass/fail.
// Kept free of state so the pipelined hazard unit can reuse it.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[NEG];
    assign z = flags[ZER];
    assign c = flags[CAR];
    assign v = flags[OVR];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV register, condition gating of decoder
// strobes, per-bit flag writes and a saturating squashed-instruction counter.
module cond_unit
    import arm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [3:0]       FlagW,
    input  logic [3:0]       ALUControl,
    input  logic             ALUOp,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic             Undef,
    output logic             CarryIn,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SquashCnt
);

    logic [3:0]       flags_q, flags_d;
    logic [3:0]       cur_flags;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic             cond_ex;
    logic             compare_op;

    // While reset is held, everything downstream already sees the cleared flags.
    assign cur_flags = reset ? 4'b0000 : flags_q;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (cur_flags),
        .cond_ex (cond_ex)
    );

    assign compare_op = ALUOp && (ALUControl[3:2] == 2'b10);

    assign CondEx    = cond_ex;
    assign PCSrc     = en && cond_ex && PCS;
    assign MemWrite  = en && cond_ex && MemW;
    assign RegWrite  = en && cond_ex && RegW && !compare_op;
    assign Undef     = en && (Cond == COND_NV);
    assign Flags     = cur_flags;
    assign CarryIn   = cur_flags[CAR];
    assign SquashCnt = squash_cnt_q;

    always_comb begin
        flags_d = flags_q;
        for (int i = 0; i < 4; i++) begin
            if (en && cond_ex && FlagW[i]) begin
                flags_d[i] = ALUFlags[i];
            end
        end

        squash_cnt_d = squash_cnt_q;
        if (cnt_clr) begin
            squash_cnt_d = '0;
        end else if (en && !cond_ex && (squash_cnt_q != '1)) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q      <= 4'b0000;
            squash_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_cond_unit;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, en, ALUOp, PCS, RegW, MemW, cnt_clr;
    logic [3:0]       Cond, ALUFlags, FlagW, ALUControl;
    logic             PCSrc, RegWrite, MemWrite, CondEx, Undef, CarryIn;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] SquashCnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_flags;
    int         m_cnt;

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .ALUControl (ALUControl),
        .ALUOp      (ALUOp),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .cnt_clr    (cnt_clr),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .CondEx     (CondEx),
        .Undef      (Undef),
        .CarryIn    (CarryIn),
        .Flags      (Flags),
        .SquashCnt  (SquashCnt)
    );

    // ARM style: cond[3:1] picks a base test, cond[0] inverts it; 111x is AL/NV.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'b1110) return 1'b1;
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic e, input logic [3:0] c,
                                 input logic [3:0] af, input logic [3:0] fw,
                                 input logic [3:0] ac, input logic aop, input logic pcs,
                                 input logic rw, input logic mw, input logic clr);
        reset = rst; en = e; Cond = c; ALUFlags = af; FlagW = fw;
        ALUControl = ac; ALUOp = aop; PCS = pcs; RegW = rw; MemW = mw; cnt_clr = clr;
    endtask

    task automatic checkOutput();
        logic [3:0] cur;
        logic       ex, is_cmp;
        cur    = reset ? 4'b0000 : m_flags;
        ex     = cond_pass(Cond, cur);
        is_cmp = ALUOp && (ALUControl >= 4'h8) && (ALUControl <= 4'hB);
        check("CondEx",    CondEx,    ex);
        check("PCSrc",     PCSrc,     en && ex && PCS);
        check("MemWrite",  MemWrite,  en && ex && MemW);
        check("RegWrite",  RegWrite,  en && ex && RegW && !is_cmp);
        check("Undef",     Undef,     en && (Cond == 4'b1111));
        check("Flags",     Flags,     cur);
        check("CarryIn",   CarryIn,   cur[1]);
        check("SquashCnt", SquashCnt, m_cnt);
    endtask

    task automatic modelEdge();
        logic ex;
        if (reset) begin
            m_flags = 4'b0000;
            m_cnt   = 0;
        end else begin
            ex = cond_pass(Cond, m_flags);
            if (en && ex) begin
                for (int i = 0; i < 4; i++) if (FlagW[i]) m_flags[i] = ALUFlags[i];
            end
            if (cnt_clr) m_cnt = 0;
            else if (en && !ex && m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    // Called 1 time unit after a rising edge: compare mid-cycle, then advance.
    task automatic step();
        #4;
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        m_flags = 4'b0000;
        m_cnt   = 0;
        applyStimulus(1, 1, 4'hE, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0, 0);
        @(posedge clk);
        modelEdge();
        #1;

        // Reset held: outputs follow cleared flags
        step();

        // 1: EQ fails on zero flags, AL passes
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0);
        #1; check("t1_condex", CondEx, 0); check("t1_pcsrc", PCSrc, 0);
        step();
        check("t1_cnt", SquashCnt, 1);
        applyStimulus(0, 1, 4'hE, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0);
        #1; check("t1_regw", RegWrite, 1);
        step();

        // 2: CMP sets flags, suppresses writeback
        applyStimulus(0, 1, 4'hE, 4'b0110, 4'hF, 4'hA, 1, 0, 1, 0, 0);
        #1; check("t2_regw", RegWrite, 0);
        step();
        check("t2_flags", Flags, 4'b0110);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
        #1; check("t2_eq", CondEx, 1);
        step();
        applyStimulus(0, 1, 4'h8, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
        #1; check("t2_hi", CondEx, 0);
        step();

        // 3: partial flag write keeps V
        applyStimulus(0, 1, 4'hE, 4'b1011, 4'hF, 4'h4, 1, 0, 1, 0, 0);
        step();
        check("t3_setup", Flags, 4'b1011);
        applyStimulus(0, 1, 4'hE, 4'b0100, 4'b1110, 4'h8, 1, 0, 0, 0, 0);
        step();
        check("t3_flags", Flags, 4'b0101);

        // 4: failed condition blocks flag write and store
        applyStimulus(0, 1, 4'hE, 4'b0000, 4'hF, 4'h4, 1, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, 4'h0, 4'hF, 4'hF, 4'h4, 1, 0, 0, 1, 0);
        #1; check("t4_memw", MemWrite, 0);
        step();
        check("t4_flags", Flags, 4'b0000);
        check("t4_cnt", SquashCnt, 3);

        // 5: stall freezes everything; NV raises Undef and counts
        applyStimulus(0, 0, 4'hE, 4'hF, 4'hF, 4'h4, 1, 1, 1, 1, 0);
        #1; check("t5_memw", MemWrite, 0);
        step();
        check("t5_flags", Flags, 4'b0000);
        check("t5_cnt", SquashCnt, 3);
        applyStimulus(0, 1, 4'hF, 4'hF, 4'hF, 4'h4, 1, 0, 0, 0, 0);
        #1; check("t5_undef", Undef, 1);
        step();
        check("t5_cnt_nv", SquashCnt, 4);

        // 6: saturation, clear-over-increment, reset mid-stream
        applyStimulus(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        check("t6_sat", SquashCnt, 15);
        applyStimulus(0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1);
        step();
        check("t6_clr", SquashCnt, 0);
        applyStimulus(0, 1, 4'hE, 4'hF, 4'hF, 4'h4, 1, 0, 0, 0, 0);
        step();
        check("t6_setf", Flags, 4'hF);
        applyStimulus(1, 1, 4'hE, 4'hF, 4'hF, 4'h4, 1, 0, 0, 0, 0);
        #1; check("t6_carry_rst", CarryIn, 0);
        step();
        check("t6_rst_flags", Flags, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic e;
            e = ($urandom_range(0, 7) != 0);
            applyStimulus($urandom_range(0, 63) == 0, e,
                          4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          e && ($urandom_range(0, 31) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
